// File: rtl/seq_dec_pkg.sv
// Shared definitions for the sequenced one-hot decoder: mode encodings and
// a wide one-hot helper that callers slice down to their own output width.
package seq_dec_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_FREEZE = 2'b11;

    localparam int MAX_SEL_W = 6;
    localparam int MAX_N_OUT = 64;

    function automatic logic [MAX_N_OUT-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_N_OUT-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for scan modes: clear has priority over hold, and tick_o
// flags the edge on which the count rolls over from DWELL-1 back to 0.
module dwell_timer #(
    parameter int DWELL   = 4,
    parameter int DWELL_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic hold_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;
    logic               advance;
    logic               at_last;

    assign advance = en_i && !hold_i && !clear_i;
    assign at_last = (cnt_q == LAST);
    assign tick_o  = advance && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (advance) begin
            cnt_d = at_last ? '0 : cnt_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_onehot_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with enable, freeze and an
// autonomous up/down scan whose active line dwells DWELL cycles per step.
module seq_onehot_decoder
    import seq_dec_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL   = 4,
    parameter int DWELL_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   dout,
    output logic [SEL_W-1:0]      index,
    output logic                  active,
    output logic                  wrap
);

    localparam int N_OUT = 2**SEL_W;

    logic [SEL_W-1:0] index_q, index_d;
    logic [N_OUT-1:0] dout_q, dout_d;
    logic             active_q, active_d;
    logic             wrap_q, wrap_d;
    logic [1:0]       prev_mode_q, prev_mode_d;
    logic             en_low_q, en_low_d;

    logic             is_scan;
    logic             scan_entry;
    logic             dir_switch;
    logic             tick;
    logic [SEL_W-1:0] index_step;
    logic [MAX_N_OUT-1:0] oh_sel;
    logic [MAX_N_OUT-1:0] oh_step;

    assign is_scan    = (mode == MODE_UP) || (mode == MODE_DOWN);
    // Re-seeding from sel happens whenever the scan was not already running.
    assign scan_entry = en && is_scan &&
                        (en_low_q || prev_mode_q == MODE_DIRECT || prev_mode_q == MODE_FREEZE);
    assign dir_switch = en && is_scan && !scan_entry && (prev_mode_q != mode);
    assign index_step = (mode == MODE_UP) ? index_q + SEL_W'(1) : index_q - SEL_W'(1);
    assign oh_sel     = onehot(MAX_SEL_W'(sel));
    assign oh_step    = onehot(MAX_SEL_W'(index_step));

    dwell_timer #(
        .DWELL   (DWELL),
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (!en || mode == MODE_DIRECT || scan_entry || dir_switch),
        .hold_i  (mode == MODE_FREEZE),
        .en_i    (is_scan),
        .tick_o  (tick)
    );

    always_comb begin
        index_d     = index_q;
        dout_d      = dout_q;
        active_d    = active_q;
        wrap_d      = 1'b0;
        prev_mode_d = prev_mode_q;
        en_low_d    = en_low_q;
        if (!en) begin
            dout_d   = '0;
            active_d = 1'b0;
            en_low_d = 1'b1;
        end else begin
            en_low_d    = 1'b0;
            prev_mode_d = mode;
            if (mode == MODE_DIRECT || scan_entry) begin
                index_d  = sel;
                dout_d   = oh_sel[N_OUT-1:0];
                active_d = 1'b1;
            end else if (is_scan) begin
                active_d = 1'b1;
                if (tick) begin
                    index_d = index_step;
                    dout_d  = oh_step[N_OUT-1:0];
                    wrap_d  = (mode == MODE_UP) ? (index_q == '1) : (index_q == '0);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q     <= '0;
            dout_q      <= '0;
            active_q    <= 1'b0;
            wrap_q      <= 1'b0;
            prev_mode_q <= MODE_DIRECT;
            en_low_q    <= 1'b0;
        end else begin
            index_q     <= index_d;
            dout_q      <= dout_d;
            active_q    <= active_d;
            wrap_q      <= wrap_d;
            prev_mode_q <= prev_mode_d;
            en_low_q    <= en_low_d;
        end
    end

    assign dout   = dout_q;
    assign index  = index_q;
    assign active = active_q;
    assign wrap   = wrap_q;

    a_dout_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(dout_q));

endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Bench for seq_onehot_decoder: four parameter variants share one stimulus
// stream and are checked every cycle against a behavioural model.
module tb_seq_onehot_decoder;

    localparam int NI = 4;

    function automatic int selw_of(input int i);
        case (i)
            0: return 2;
            1: return 2;
            2: return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int dwell_of(input int i);
        case (i)
            0: return 4;
            1: return 1;
            2: return 2;
            default: return 3;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] sel_all = 4'd0;

    logic [15:0] dout_w   [NI];
    logic [3:0]  index_w  [NI];
    logic        active_w [NI];
    logic        wrap_w   [NI];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int SW = selw_of(gi);
        localparam int DW = dwell_of(gi);
        logic [2**SW-1:0] dout;
        logic [SW-1:0]    index;
        logic             active;
        logic             wrap;

        seq_onehot_decoder #(
            .SEL_W   (SW),
            .DWELL   (DW),
            .DWELL_W (16)
        ) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .mode   (mode),
            .sel    (sel_all[SW-1:0]),
            .dout   (dout),
            .index  (index),
            .active (active),
            .wrap   (wrap)
        );

        assign dout_w[gi]   = 16'(dout);
        assign index_w[gi]  = 4'(index);
        assign active_w[gi] = active;
        assign wrap_w[gi]   = wrap;
    end

    task automatic chk(input string nm, input int inst, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d t=%0t got %h want %h", nm, inst, $time, act, exp);
        end
    endtask

    // Behavioural model: position, cycles spent at it, and whether the scan must re-seed.
    int m_idx [NI];
    int m_cnt [NI];
    int m_prev[NI];
    bit m_act [NI];
    bit m_wrap[NI];
    bit m_need[NI];

    task automatic model_reset(input int i);
        m_idx[i] = 0; m_cnt[i] = 0; m_prev[i] = 0;
        m_act[i] = 0; m_wrap[i] = 0; m_need[i] = 0;
    endtask

    task automatic model_step(input int i, input bit en_s, input int mode_s, input int sel_s);
        int n;
        int d;
        n = 1 << selw_of(i);
        d = dwell_of(i);
        m_wrap[i] = 0;
        if (!en_s) begin
            m_act[i] = 0; m_cnt[i] = 0; m_need[i] = 1;
            return;
        end
        if (mode_s == 0) begin
            m_idx[i] = sel_s % n; m_act[i] = 1; m_cnt[i] = 0;
        end else if (mode_s == 1 || mode_s == 2) begin
            if (m_need[i] || m_prev[i] == 0 || m_prev[i] == 3) begin
                m_idx[i] = sel_s % n; m_act[i] = 1; m_cnt[i] = 0;
            end else if (m_prev[i] != mode_s) begin
                m_cnt[i] = 0;
            end else if (m_cnt[i] == d - 1) begin
                m_cnt[i] = 0;
                if (mode_s == 1) begin
                    m_wrap[i] = (m_idx[i] == n - 1);
                    m_idx[i]  = (m_idx[i] + 1) % n;
                end else begin
                    m_wrap[i] = (m_idx[i] == 0);
                    m_idx[i]  = (m_idx[i] + n - 1) % n;
                end
            end else begin
                m_cnt[i]++;
            end
        end
        m_prev[i] = mode_s;
        m_need[i] = 0;
    endtask

    initial begin
        bit en_s;
        bit rst_s;
        int mode_s;
        int sel_s;
        logic [15:0] exp_dout;
        forever begin
            @(posedge clk);
            en_s = en; rst_s = rst_n; mode_s = int'(mode); sel_s = int'(sel_all);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (!rst_s) model_reset(i);
                else model_step(i, en_s, mode_s, sel_s);
                exp_dout = m_act[i] ? (16'd1 << m_idx[i]) : 16'd0;
                chk("model_dout", i, dout_w[i], exp_dout);
                chk("model_index", i, 16'(index_w[i]), 16'(m_idx[i]));
                chk("model_active", i, 16'(active_w[i]), 16'(m_act[i]));
                chk("model_wrap", i, 16'(wrap_w[i]), 16'(m_wrap[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [15:0] seq_down [5];
        seq_down = '{16'h1, 16'h8, 16'h4, 16'h2, 16'h1};

        // Reset, then direct decode
        repeat (3) tick();
        chk("reset_dout", 0, dout_w[0], 16'h0);
        chk("reset_index", 0, 16'(index_w[0]), 16'h0);
        chk("reset_active", 0, 16'(active_w[0]), 16'h0);
        chk("reset_wrap", 0, 16'(wrap_w[0]), 16'h0);
        rst_n = 1; en = 1; mode = 2'b00; sel_all = 4'd2;
        tick();
        chk("direct_sel2", 0, dout_w[0], 16'b0100);
        chk("direct_active", 0, 16'(active_w[0]), 16'h1);
        sel_all = 4'd3;
        tick();
        chk("direct_sel3", 0, dout_w[0], 16'b1000);
        $display("[TB] direct phase done");

        // Scan-up from 1, dwell 4, wrap after three steps
        mode = 2'b01; sel_all = 4'd1;
        for (int k = 0; k < 13; k++) begin
            tick();
            chk("scanup_dout", 0, dout_w[0], 16'd1 << ((1 + k / 4) % 4));
            chk("scanup_wrap", 0, 16'(wrap_w[0]), 16'(k == 12));
        end
        $display("[TB] scan-up phase done");

        // Scan-down on the DWELL=1 variant
        mode = 2'b00; sel_all = 4'd0;
        tick();
        mode = 2'b10;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("scandown_dout", 1, dout_w[1], seq_down[k]);
            chk("scandown_wrap", 1, 16'(wrap_w[1]), 16'(k == 1));
        end
        $display("[TB] scan-down phase done");

        // Freeze mid-dwell, re-entry reload, then direction change
        mode = 2'b00; sel_all = 4'd2;
        tick();
        mode = 2'b01;
        repeat (3) tick();
        mode = 2'b11;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("freeze_dout", 0, dout_w[0], 16'b0100);
            chk("freeze_wrap", 0, 16'(wrap_w[0]), 16'h0);
        end
        mode = 2'b01; sel_all = 4'd0;
        tick();
        chk("unfreeze_reload", 0, dout_w[0], 16'b0001);
        tick();
        mode = 2'b10;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("dirchg_dout", 0, dout_w[0], (k < 4) ? 16'b0001 : 16'b1000);
        end
        $display("[TB] freeze/direction phase done");

        // Enable drop and re-entry, then asynchronous reset
        mode = 2'b00; sel_all = 4'd3;
        tick();
        en = 0;
        tick();
        chk("en_low_dout", 0, dout_w[0], 16'h0);
        chk("en_low_active", 0, 16'(active_w[0]), 16'h0);
        en = 1; mode = 2'b01; sel_all = 4'd1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("en_reentry_dout", 0, dout_w[0], (k < 4) ? 16'b0010 : 16'b0100);
        end
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("async_rst_dout", 0, dout_w[0], 16'h0);
        chk("async_rst_index", 0, 16'(index_w[0]), 16'h0);
        chk("async_rst_active", 0, 16'(active_w[0]), 16'h0);
        tick();
        rst_n = 1;
        $display("[TB] enable/reset phase done");

        // Randomised traffic across all variants
        for (int c = 0; c < 3000; c++) begin
            tick();
            en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            sel_all = 4'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 0;
                tick();
                tick();
                rst_n = 1;
            end
        end
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
